axi_lite_gpio: RTL and testbench

AXI4-Lite slave GPIO peripheral on the S1 (peripheral) port of the SoC interconnect, at base 0x1000_0000. It consumes the CPU's peripheral reads and writes and drives the SoC-level gpio_out/gpio_oe pins. It samples gpio_in through a synchronizer, latches rising edges, and raises a level interrupt. The interconnect strips the base, so the block decodes only the low ADDR_W bits.

---
 rtl/axi_lite_gpio.sv | 236 +++++++++++++++++++++++
 tb/tb_axi_lite_gpio.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_gpio.sv
// axi_lite_gpio
// AXI4-Lite slave GPIO peripheral. Holds the OUT/OE pin registers,
// samples gpio_in through a two-flop synchronizer, latches rising edges
// into sticky EDGE flags and raises a registered level interrupt.
//
// Register map (byte offsets, low ADDR_W address bits only):
//   0x00 OUT    RW
//   0x04 OE     RW
//   0x08 IN     RO  (writes accepted and ignored)
//   0x0C SET    WO  OUT |= data
//   0x10 CLR    WO  OUT &= ~data
//   0x14 EDGE   RW1C
//   0x18 IRQ_EN RW
// Any other or unaligned address answers SLVERR and changes nothing.
//
// Ports:
//   aclk, areset            clock, synchronous active-high reset
//   s_axi_aw*/w*/b*         AXI4-Lite write channels
//   s_axi_ar*/r*            AXI4-Lite read channels
//   gpio_in                 asynchronous pin inputs
//   gpio_out, gpio_oe       OUT and OE register values
//   irq                     registered |(EDGE & IRQ_EN)

module axi_lite_gpio #(
  parameter int ADDR_W = 12,
  parameter int GPIO_W = 16
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Register indices taken from address bits [4:2]
  localparam logic [2:0] IDX_OUT    = 3'd0;
  localparam logic [2:0] IDX_OE     = 3'd1;
  localparam logic [2:0] IDX_IN     = 3'd2;
  localparam logic [2:0] IDX_SET    = 3'd3;
  localparam logic [2:0] IDX_CLR    = 3'd4;
  localparam logic [2:0] IDX_EDGE   = 3'd5;
  localparam logic [2:0] IDX_IRQ_EN = 3'd6;

  // A legal address is word aligned, has nothing set above bit 4 and
  // does not land on the unused slot 0x1C.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> 5) == '0) && (a[4:2] != 3'd7);
  endfunction

  // Write-side one-entry slots
  logic              aw_full;
  logic [ADDR_W-1:0] aw_addr;
  logic              w_full;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;

  // Register state
  logic [GPIO_W-1:0] out_reg;
  logic [GPIO_W-1:0] oe_reg;
  logic [GPIO_W-1:0] edge_flags;
  logic [GPIO_W-1:0] irq_en_reg;

  // Synchronizer (s1, s2) and previous-value flop (s3)
  logic [GPIO_W-1:0] sync_s1;
  logic [GPIO_W-1:0] sync_s2;
  logic [GPIO_W-1:0] sync_s3;

  // Combinational helpers
  logic [31:0]       strb_mask32;
  logic [31:0]       wbits32;
  logic [GPIO_W-1:0] wmask;
  logic [GPIO_W-1:0] wbits;
  logic              commit;
  logic              wr_ok;
  logic [GPIO_W-1:0] w1c_mask;
  logic [GPIO_W-1:0] rise;
  logic              rd_ok;
  logic [GPIO_W-1:0] rd_val;
  logic [31:0]       rd_data;
  logic              unused_wbits;

  assign s_axi_awready = !aw_full && !s_axi_bvalid;
  assign s_axi_wready  = !w_full && !s_axi_bvalid;
  assign s_axi_arready = !s_axi_rvalid;

  assign gpio_out = out_reg;
  assign gpio_oe  = oe_reg;

  // Byte strobes gate the write data for every write-type register;
  // lanes above GPIO_W simply fall off when the word is narrowed.
  always_comb begin
    strb_mask32 = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};
    wbits32     = w_data & strb_mask32;
    wmask       = strb_mask32[GPIO_W-1:0];
    wbits       = wbits32[GPIO_W-1:0];
  end

  assign unused_wbits = ^{strb_mask32, wbits32};

  // A write commits on the edge after both slots hold their halves
  assign commit = aw_full && w_full;
  assign wr_ok  = addr_ok(aw_addr);

  // Edge clear mask only exists on the commit cycle of a legal EDGE write
  always_comb begin
    w1c_mask = '0;
    if (commit && wr_ok && (aw_addr[4:2] == IDX_EDGE)) begin
      w1c_mask = wbits;
    end
  end

  assign rise = sync_s2 & ~sync_s3;

  // Read mux: narrow register values are zero-extended to 32 bits,
  // write-only and illegal addresses read as zero.
  always_comb begin
    rd_ok   = addr_ok(s_axi_araddr);
    rd_val  = '0;
    rd_data = '0;
    case (s_axi_araddr[4:2])
      IDX_OUT:    rd_val = out_reg;
      IDX_OE:     rd_val = oe_reg;
      IDX_IN:     rd_val = sync_s2;
      IDX_EDGE:   rd_val = edge_flags;
      IDX_IRQ_EN: rd_val = irq_en_reg;
      default:    rd_val = '0;
    endcase
    if (rd_ok) begin
      rd_data[GPIO_W-1:0] = rd_val;
    end
  end

  // Input synchronizer, sticky edge flags and the registered interrupt.
  // The rise term is OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge aclk) begin
    if (areset) begin
      sync_s1    <= '0;
      sync_s2    <= '0;
      sync_s3    <= '0;
      edge_flags <= '0;
      irq        <= 1'b0;
    end else begin
      sync_s1    <= gpio_in;
      sync_s2    <= sync_s1;
      sync_s3    <= sync_s2;
      edge_flags <= (edge_flags & ~w1c_mask) | rise;
      irq        <= |(edge_flags & irq_en_reg);
    end
  end

  // Write path: independent AW/W capture, commit when both are present,
  // then hold the response until the master takes it. Slots cannot fill
  // while bvalid is up, so commit and the B handshake never overlap.
  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_full      <= 1'b0;
      aw_addr      <= '0;
      w_full       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
      out_reg      <= '0;
      oe_reg       <= '0;
      irq_en_reg   <= '0;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_full <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (commit) begin
        aw_full      <= 1'b0;
        w_full       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        s_axi_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        if (wr_ok) begin
          case (aw_addr[4:2])
            IDX_OUT:    out_reg    <= (out_reg & ~wmask) | wbits;
            IDX_OE:     oe_reg     <= (oe_reg & ~wmask) | wbits;
            IDX_SET:    out_reg    <= out_reg | wbits;
            IDX_CLR:    out_reg    <= out_reg & ~wbits;
            IDX_IRQ_EN: irq_en_reg <= (irq_en_reg & ~wmask) | wbits;
            default:    ;
          endcase
        end
      end
    end
  end

  // Read path: capture data on the AR handshake and hold it until taken
  always_ff @(posedge aclk) begin
    if (areset) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else begin
      if (s_axi_arvalid && s_axi_arready) begin
        s_axi_rvalid <= 1'b1;
        s_axi_rdata  <= rd_data;
        s_axi_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
      end else if (s_axi_rvalid && s_axi_rready) begin
        s_axi_rvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_gpio.sv
// tb_axi_lite_gpio
// Self-checking bench for axi_lite_gpio. Expected write responses and
// read results are queued when a transaction is driven and popped when
// the DUT presents its response. Pin-level results are compared inline.

module tb_axi_lite_gpio;

  localparam int ADDR_W = 12;
  localparam int GPIO_W = 16;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic              aclk = 1'b0;
  logic              areset;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rvalid;
  logic              s_axi_rready;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic [GPIO_W-1:0] gpio_oe;
  logic              irq;

  int checks = 0;
  int errors = 0;

  logic [1:0]  bq[$];
  logic [33:0] rq[$];

  axi_lite_gpio #(.ADDR_W(ADDR_W), .GPIO_W(GPIO_W)) dut (
    .aclk(aclk),
    .areset(areset),
    .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata),
    .s_axi_wstrb(s_axi_wstrb),
    .s_axi_wvalid(s_axi_wvalid),
    .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .gpio_oe(gpio_oe),
    .irq(irq)
  );

  always #5 aclk = ~aclk;

  // Advance one rising edge and settle away from it
  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_pins(input string name, input logic [GPIO_W-1:0] exp_out,
                            input logic [GPIO_W-1:0] exp_oe);
    checks++;
    if ({gpio_out, gpio_oe} !== {exp_out, exp_oe}) begin
      errors++;
      $display("[TB] FAIL %s: out/oe got %h/%h expected %h/%h", name, gpio_out, gpio_oe,
               exp_out, exp_oe);
    end
  endtask

  task automatic check_irq(input string name, input logic exp_irq);
    checks++;
    if (irq !== exp_irq) begin
      errors++;
      $display("[TB] FAIL %s: irq got %b expected %b", name, irq, exp_irq);
    end
  endtask

  // AW and W together, bready held high; response checked from the queue
  task automatic axi_write(input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp,
                           input string name);
    logic aw_done, w_done, aw_hs, w_hs;
    logic [1:0] exp;
    int cyc;
    bq.push_back(exp_resp);
    s_axi_awaddr = addr; s_axi_awvalid = 1'b1;
    s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    aw_done = 1'b0; w_done = 1'b0; cyc = 0;
    while (!(aw_done && w_done) && cyc < 20) begin
      aw_hs = s_axi_awvalid && s_axi_awready;
      w_hs  = s_axi_wvalid && s_axi_wready;
      step(); cyc++;
      if (aw_hs) begin aw_done = 1'b1; s_axi_awvalid = 1'b0; end
      if (w_hs)  begin w_done  = 1'b1; s_axi_wvalid  = 1'b0; end
    end
    while (!s_axi_bvalid && cyc < 20) begin step(); cyc++; end
    checks++;
    if (!s_axi_bvalid) begin
      errors++;
      void'(bq.pop_front());
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      $display("[TB] FAIL %s: bvalid got 0 expected 1 (timeout)", name);
    end else begin
      exp = bq.pop_front();
      if (s_axi_bresp !== exp) begin
        errors++;
        $display("[TB] FAIL %s: bresp got %b expected %b", name, s_axi_bresp, exp);
      end
      step();
    end
    s_axi_bready = 1'b0;
  endtask

  // Read with rready held low for one cycle so the hold of rdata is seen too
  task automatic axi_read(input logic [ADDR_W-1:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input string name);
    logic [33:0] exp;
    int cyc;
    rq.push_back({exp_data, exp_resp});
    s_axi_araddr = addr; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
    cyc = 0;
    while (!s_axi_arready && cyc < 20) begin step(); cyc++; end
    step();
    s_axi_arvalid = 1'b0;
    checks++;
    if (!s_axi_rvalid) begin
      errors++;
      void'(rq.pop_front());
      $display("[TB] FAIL %s: rvalid got 0 expected 1", name);
    end else begin
      exp = rq.pop_front();
      if ({s_axi_rdata, s_axi_rresp} !== exp) begin
        errors++;
        $display("[TB] FAIL %s: rdata/rresp got %h/%b expected %h/%b", name, s_axi_rdata,
                 s_axi_rresp, exp[33:2], exp[1:0]);
      end
      step();
      checks++;
      if (!s_axi_rvalid || {s_axi_rdata, s_axi_rresp} !== exp) begin
        errors++;
        $display("[TB] FAIL %s hold: rvalid/rdata got %b/%h expected 1/%h", name,
                 s_axi_rvalid, s_axi_rdata, exp[33:2]);
      end
      s_axi_rready = 1'b1;
      step();
      s_axi_rready = 1'b0;
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b0; s_axi_araddr = '0; s_axi_arvalid = 1'b0;
    s_axi_rready = 1'b0; gpio_in = '0;
    step(); step();
    areset = 1'b0;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, irq}
        !== 6'b111000) begin
      errors++;
      $display("[TB] FAIL reset flags: got %b expected 111000",
               {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid, irq});
    end
    check_pins("reset pins", 16'h0000, 16'h0000);
    axi_read(12'h000, 32'h0, OKAY, "reset read OUT");
  endtask

  task automatic test_basic_write();
    axi_write(12'h000, 32'h0000_0055, 4'b1111, OKAY, "write OUT");
    axi_write(12'h004, 32'h0000_FFFF, 4'b0001, OKAY, "write OE strb0");
    check_pins("basic write", 16'h0055, 16'h00FF);
    axi_read(12'h004, 32'h0000_00FF, OKAY, "read OE");
  endtask

  task automatic test_w_before_aw();
    logic [1:0] exp;
    axi_write(12'h000, 32'h0000_1234, 4'b1111, OKAY, "preload OUT");
    bq.push_back(OKAY);
    s_axi_bready = 1'b0;
    s_axi_wdata = 32'h0000_0055; s_axi_wstrb = 4'b1111; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    for (int i = 0; i < 2; i++) step();
    checks++;
    if (s_axi_bvalid !== 1'b0 || gpio_out !== 16'h1234 || s_axi_wready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w-first early: bvalid/out/wready got %b/%h/%b expected 0/1234/0",
               s_axi_bvalid, gpio_out, s_axi_wready);
    end
    s_axi_awaddr = 12'h000; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0 || gpio_out !== 16'h1234) begin
      errors++;
      $display("[TB] FAIL w-first capture: bvalid/out got %b/%h expected 0/1234",
               s_axi_bvalid, gpio_out);
    end
    step();
    check_pins("w-first commit", 16'h0055, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (s_axi_bvalid !== 1'b1 || s_axi_awready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL w-first hold %0d: bvalid/awready got %b/%b expected 1/0", i,
                 s_axi_bvalid, s_axi_awready);
      end
    end
    exp = bq.pop_front();
    checks++;
    if (s_axi_bresp !== exp) begin
      errors++;
      $display("[TB] FAIL w-first bresp: got %b expected %b", s_axi_bresp, exp);
    end
    s_axi_bready = 1'b1;
    step();
    s_axi_bready = 1'b0;
    checks++;
    if (s_axi_bvalid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL w-first release: bvalid got %b expected 0", s_axi_bvalid);
    end
    axi_write(12'h00C, 32'h0000_0F00, 4'b1111, OKAY, "SET");
    check_pins("after SET", 16'h0F55, 16'h00FF);
    axi_write(12'h010, 32'h0000_0005, 4'b1111, OKAY, "CLR");
    check_pins("after CLR", 16'h0F50, 16'h00FF);
    axi_read(12'h00C, 32'h0, OKAY, "read SET");
  endtask

  task automatic test_strobes();
    axi_write(12'h004, 32'h0000_1234, 4'b0011, OKAY, "OE strb 0011");
    check_pins("OE strb 0011", 16'h0F50, 16'h1234);
    axi_write(12'h004, 32'hFFFF_FFFF, 4'b0010, OKAY, "OE strb 0010");
    check_pins("OE strb 0010", 16'h0F50, 16'hFF34);
    axi_write(12'h00C, 32'hFFFF_FFFF, 4'b0001, OKAY, "SET strb 0001");
    check_pins("SET strb 0001", 16'h0FFF, 16'hFF34);
    axi_write(12'h010, 32'h0000_00AF, 4'b1111, OKAY, "CLR back");
    check_pins("CLR back", 16'h0F50, 16'hFF34);
  endtask

  task automatic test_slverr();
    axi_write(12'h100, 32'hFFFF_FFFF, 4'b1111, SLVERR, "write 0x100");
    axi_write(12'h202, 32'hFFFF_FFFF, 4'b1111, SLVERR, "write 0x202");
    axi_write(12'h01C, 32'hFFFF_FFFF, 4'b1111, SLVERR, "write 0x01C");
    check_pins("after SLVERR", 16'h0F50, 16'hFF34);
    axi_read(12'h100, 32'h0, SLVERR, "read 0x100");
    axi_read(12'h202, 32'h0, SLVERR, "read 0x202");
  endtask

  task automatic test_edge_irq();
    axi_write(12'h018, 32'h0000_0008, 4'b1111, OKAY, "IRQ_EN");
    gpio_in = 16'h0008;
    step(); step(); step();
    check_irq("irq before lag", 1'b0);
    step();
    check_irq("irq set", 1'b1);
    axi_read(12'h014, 32'h0000_0008, OKAY, "read EDGE");
    axi_read(12'h008, 32'h0000_0008, OKAY, "read IN");
    axi_write(12'h014, 32'h0000_0008, 4'b1111, OKAY, "W1C EDGE");
    check_irq("irq cleared", 1'b0);
    axi_read(12'h014, 32'h0, OKAY, "EDGE after W1C");
    // Raise again so bit3 is set before the coinciding clear
    gpio_in = 16'h0000;
    for (int i = 0; i < 4; i++) step();
    gpio_in = 16'h0008;
    for (int i = 0; i < 4; i++) step();
    gpio_in = 16'h0000;
    for (int i = 0; i < 4; i++) step();
    gpio_in = 16'h0008;
    step();
    axi_write(12'h014, 32'h0000_0008, 4'b1111, OKAY, "W1C with rise");
    axi_read(12'h014, 32'h0000_0008, OKAY, "EDGE set wins");
    check_irq("irq after set wins", 1'b1);
  endtask

  task automatic test_reset_mid();
    gpio_in = 16'h0000;
    s_axi_awaddr = 12'h000; s_axi_awvalid = 1'b1;
    step();
    s_axi_awvalid = 1'b0;
    checks++;
    if (s_axi_awready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid aw captured: awready got %b expected 0", s_axi_awready);
    end
    areset = 1'b1;
    step();
    areset = 1'b0;
    checks++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, irq} !== 4'b1100) begin
      errors++;
      $display("[TB] FAIL mid reset flags: got %b expected 1100",
               {s_axi_awready, s_axi_wready, s_axi_bvalid, irq});
    end
    check_pins("mid reset pins", 16'h0000, 16'h0000);
    s_axi_wdata = 32'h0000_FFFF; s_axi_wstrb = 4'b1111; s_axi_wvalid = 1'b1;
    step();
    s_axi_wvalid = 1'b0;
    step(); step();
    checks++;
    if (s_axi_bvalid !== 1'b0 || gpio_out !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL mid no response: bvalid/out got %b/%h expected 0/0000",
               s_axi_bvalid, gpio_out);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic_write();
    test_w_before_aw();
    test_strobes();
    test_slverr();
    test_edge_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
